// File: rtl/pwr_restore_unit_pkg.sv
// Shared types and entry-layout helpers for the power-on restore controller.
package pwr_restore_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_POP,
    ST_LATCH,
    ST_WRITE,
    ST_CLEAR,
    ST_DONE
  } restoreState_e;

  localparam int RESTORE_K = 10;
  localparam int RESTORE_N = 32;

  // Floor of one bit so a single-wrapper build still has a usable address field.
  function automatic int calcLog2K(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  function automatic int entryValLsb(input int k);
    return calcLog2K(k);
  endfunction

  function automatic int entryValMsb(input int n, input int k);
    return n + calcLog2K(k) - 1;
  endfunction

  localparam int RESTORE_ADDR_W  = calcLog2K(RESTORE_K);
  localparam int RESTORE_VAL_LSB = entryValLsb(RESTORE_K);
  localparam int RESTORE_VAL_MSB = entryValMsb(RESTORE_N, RESTORE_K);

endpackage

// File: rtl/pwr_restore_unit_fsm_restore.sv
// Restore sequencer: walks CHECK/POP/LATCH/WRITE per buffer entry, then CLEAR/DONE.
module fsm_restore
  import pwr_restore_unit_pkg::*;
(
  input  logic Clk_i,
  input  logic Rst_i,
  input  logic Pwr_off_i,
  input  logic Start_Restore_i,
  input  logic IsEmpty_Buffer_i,
  output logic PopEn_o,
  output logic RstBuf_o,
  output logic Done_o,
  output logic Busy_o,
  output logic WriteStb_o,
  output logic LatchEn_o,
  output logic StartAccept_o
);

  restoreState_e state_q, state_d;

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (Start_Restore_i) state_d = ST_CHECK;
      ST_CHECK: state_d = IsEmpty_Buffer_i ? ST_CLEAR : ST_POP;
      ST_POP:   state_d = ST_LATCH;
      ST_LATCH: state_d = ST_WRITE;
      ST_WRITE: state_d = ST_CHECK;
      ST_CLEAR: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Power loss overrides everything, including a start in the same cycle.
    if (Pwr_off_i) state_d = ST_IDLE;
  end

  always_comb begin
    PopEn_o       = (state_q == ST_POP);
    RstBuf_o      = (state_q == ST_CLEAR);
    Done_o        = (state_q == ST_DONE);
    Busy_o        = (state_q != ST_IDLE);
    WriteStb_o    = (state_q == ST_WRITE);
    LatchEn_o     = (state_q == ST_LATCH);
    StartAccept_o = (state_q == ST_IDLE) && Start_Restore_i && !Pwr_off_i;
  end

endmodule

// File: rtl/pwr_restore_unit.sv
// Power-on restore controller top: entry register, range check, one-hot enable decode.
// Optional error counter enabled by defining RESTORE_ERR_CNT_EN.
module pwr_restore_unit
  import pwr_restore_unit_pkg::*;
#(
  parameter  int K      = RESTORE_K,
  parameter  int N      = RESTORE_N,
  localparam int LOG2_K = calcLog2K(K)
) (
  input  logic              Clk_i,
  input  logic              Rst_i,
  input  logic              Pwr_off_i,
  input  logic              Start_Restore_i,
  input  logic [N+LOG2_K-1:0] PopVal_Buffer_i,
  input  logic              IsEmpty_Buffer_i,
  output logic              PopEn_Buffer_o,
  output logic              Rst_Buffer_o,
  output logic [N-1:0]      Restore_Vout_IC_Reg_Wrapper_o,
  output logic [K-1:0]      Restore_Ens_IC_Reg_Wrapper_o,
  output logic              Busy_Restore_o,
  output logic              Done_Restore_o
`ifdef RESTORE_ERR_CNT_EN
  ,
  output logic [LOG2_K:0]   Err_Cnt_Restore_o,
  output logic              Err_Restore_o
`endif
);

  localparam int VAL_LSB = entryValLsb(K);
  localparam int VAL_MSB = entryValMsb(N, K);
  localparam logic [LOG2_K:0] K_LIM = (LOG2_K+1)'(K);

  logic writeStb, latchEn, startAccept, busy;
  logic [N+LOG2_K-1:0] entry_q, entry_d;
  logic [LOG2_K-1:0] entryAddr;
  logic [N-1:0] entryVal;
  logic inRange;

  fsm_restore uFsm (
    .Clk_i            (Clk_i),
    .Rst_i            (Rst_i),
    .Pwr_off_i        (Pwr_off_i),
    .Start_Restore_i  (Start_Restore_i),
    .IsEmpty_Buffer_i (IsEmpty_Buffer_i),
    .PopEn_o          (PopEn_Buffer_o),
    .RstBuf_o         (Rst_Buffer_o),
    .Done_o           (Done_Restore_o),
    .Busy_o           (busy),
    .WriteStb_o       (writeStb),
    .LatchEn_o        (latchEn),
    .StartAccept_o    (startAccept)
  );

  // Buffer data arrives one cycle after the pop, which is the LATCH cycle.
  always_comb begin
    entry_d = entry_q;
    if (latchEn)   entry_d = PopVal_Buffer_i;
    if (Pwr_off_i) entry_d = '0;
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) entry_q <= '0;
    else       entry_q <= entry_d;
  end

  assign entryAddr = entry_q[LOG2_K-1:0];
  assign entryVal  = entry_q[VAL_MSB:VAL_LSB];
  assign inRange   = ({1'b0, entryAddr} < K_LIM);

  always_comb begin
    Restore_Ens_IC_Reg_Wrapper_o = '0;
    if (writeStb && inRange) Restore_Ens_IC_Reg_Wrapper_o[entryAddr] = 1'b1;
  end

  assign Restore_Vout_IC_Reg_Wrapper_o = busy ? entryVal : '0;
  assign Busy_Restore_o = busy;

`ifdef RESTORE_ERR_CNT_EN
  logic [LOG2_K:0] errCnt_q, errCnt_d;
  logic err_q, err_d;

  // Count survives Pwr_off so a post-mortem can still see dropped entries.
  always_comb begin
    errCnt_d = errCnt_q;
    err_d    = err_q;
    if (startAccept) begin
      errCnt_d = '0;
      err_d    = 1'b0;
    end else if (writeStb && !inRange) begin
      if (errCnt_q != '1) errCnt_d = errCnt_q + 1'b1;
      err_d = 1'b1;
    end
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      errCnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      errCnt_q <= errCnt_d;
      err_q    <= err_d;
    end
  end

  assign Err_Cnt_Restore_o = errCnt_q;
  assign Err_Restore_o     = err_q;
`else
  logic unusedStartAccept;
  assign unusedStartAccept = startAccept;
`endif

endmodule
